ffe_adapt_sequencer: RTL and testbench
======================================

Name: ffe_adapt_sequencer

Overview:
- Adaptation controller for the parallel PAM4 FFE. It sits between the P-lane FIR/slicer outputs and the adaptation engine.
- Rotates the lane fed to adaptation instead of always using the newest lane, and decimates coefficient updates.
- Runs a CMA-acquisition → LMS-tracking mode FSM, gated by a windowed mean-squared-error lock detector.
- Anneals the LMS step size after lock and supports freeze and forced re-acquisition.

Parameters:
- PARALLELISM, 8, samples per clock (lanes); power of two.
- NB_OUT, 18, FIR/slicer sample width.
- NBF_OUT, 15, FIR/slicer fractional bits.
- NB_MU, 16, step-size width.
- NB_ERR_ACC, 40, error-energy accumulator width.
- DECIM, 4, valid cycles per adaptation tick (≥1).
- ERR_WIN_LOG2, 10, log2 of ticks per error-energy window.
- CMA_MIN_TICKS, 4096, minimum ticks spent in CMA before lock is allowed.
- MU_SHIFT_MAX, 4, maximum LMS step-size right shift.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  synchronous active-high reset.
- i_en  in  1  global enable.
- i_valid  in  1  input beat valid.
- i_fir_flat  in  PARALLELISM*NB_OUT  FIR outputs; lane k at [(k+1)*NB_OUT-1 -: NB_OUT], lane 0 oldest.
- i_slicer_flat  in  PARALLELISM*NB_OUT  slicer decisions, same packing.
- i_mu_cma  in  NB_MU  CMA step size.
- i_mu_lms  in  NB_MU  LMS step size.
- i_lock_thr  in  NB_ERR_ACC  lock threshold on mean e², Q(.,2*NBF_OUT).
- i_freeze  in  1  level: hold coefficients.
- i_force_cma  in  1  pulse: force re-acquisition.
- o_lane_sel  out  clog2(PARALLELISM)  lane currently sampled.
- o_fir_sel  out  NB_OUT  registered FIR sample of selected lane.
- o_slicer_sel  out  NB_OUT  registered slicer sample of selected lane.
- o_mode  out  1  0 = CMA, 1 = LMS.
- o_mu  out  NB_MU  step size for the adaptation engine.
- o_update_en  out  1  one-cycle coefficient-update strobe.
- o_state  out  2  0 = IDLE, 1 = CMA_ACQ, 2 = LMS_TRACK, 3 = FROZEN.
- o_locked  out  1  lock flag.
- o_err_energy  out  NB_ERR_ACC  last window mean e².

Behaviour:
- adv = i_en & i_valid. With i_en low, all counters, the accumulator and the FSM hold, and o_update_en = 0.
- Reset: every output, counter and accumulator is 0; state is IDLE. Reset mid-operation aborts the current window with no o_err_energy update.
- Decimation counter counts 0..DECIM-1 on adv. A tick occurs on the adv where the counter equals DECIM-1; the counter then wraps to 0.
- On each tick:
  - o_fir_sel and o_slicer_sel load lane o_lane_sel from the current inputs.
  - o_lane_sel then increments, wrapping PARALLELISM-1 → 0.
- Latency: the selection registers update 1 cycle after the tick. o_update_en pulses in that same cycle, only if the state is CMA_ACQ or LMS_TRACK.
- Error: e = o_fir_sel - o_slicer_sel, sign-extended to NB_OUT+1 bits. e² is exact, with 2*NBF_OUT fractional bits.
  - e² is added to the accumulator one cycle after each selection update, in every state except IDLE.
  - The add saturates at 2^NB_ERR_ACC - 1.
- Window end, after 2^ERR_WIN_LOG2 accumulations:
  - o_err_energy ← acc >> ERR_WIN_LOG2.
  - acc is cleared. If an accumulation coincides with the clear, the accumulator takes that e² rather than 0.
- FSM:
  - IDLE → CMA_ACQ on the first adv.
  - CMA_ACQ: o_mode = 0, o_mu = i_mu_cma. The tick counter saturates at CMA_MIN_TICKS. At a window end with the counter saturated and the new energy < i_lock_thr: → LMS_TRACK, o_locked = 1, mu shift = 0.
  - LMS_TRACK: o_mode = 1, o_mu = i_mu_lms >>> shift (arithmetic). At each window end with energy < i_lock_thr, shift increments, saturating at MU_SHIFT_MAX. At a window end with energy ≥ 2*i_lock_thr (hysteresis): → CMA_ACQ, o_locked = 0, tick counter cleared.
  - FROZEN: entered from CMA_ACQ or LMS_TRACK while i_freeze = 1. o_update_en = 0. o_mode, o_mu, o_locked and the shift hold. Energy windows continue but cause no transitions. On i_freeze = 0, returns to the state it came from.
- Priority: reset > i_force_cma > i_freeze > window-end transitions.
  - i_force_cma from any non-IDLE state: → CMA_ACQ, o_locked = 0, tick counter and shift cleared, accumulator and window counter cleared.
- o_state, o_mode and o_locked are registered; all change in the same cycle as the transition.

Optional Feature:
- Macro: MU_ANNEAL_EN.
- Defined: LMS step-size annealing as above.
- Undefined: o_mu = i_mu_lms throughout LMS_TRACK; the shift register is not built.

Test Plan:
- Lane rotation (P=8, DECIM=4, continuous adv, lane k FIR value = k): o_update_en every 4th cycle; o_fir_sel sequence 0,1,...,7,0; o_lane_sel wraps 7→0.
- Lock (ERR_WIN_LOG2=4, CMA_MIN_TICKS=32, thr = 2^20; FIR−slicer = 2^-10 in Q.15, so e² = 2^10): o_err_energy = 1024; → LMS_TRACK after the first window end at or after tick 32; o_locked = 1; o_mu = i_mu_lms = 0x4000, then 0x2000, 0x1000, 0x0800, 0x0400, then held at 0x0400.
- Unlock: from lock, raise the error to 2^-4 (e² = 2^22 ≥ 2*thr) → CMA_ACQ at the next window end; o_locked = 0; o_mu = i_mu_cma.
- Freeze/force: i_freeze = 1 in LMS_TRACK → o_state = 3, no o_update_en; release → o_state = 2, shift unchanged. Then pulse i_force_cma → o_state = 1, o_mu = i_mu_cma.
- Enable/saturation/reset: i_en = 0 for 10 cycles → no ticks and outputs frozen. NB_ERR_ACC = 24 with FIR = +1.99, slicer = −1.99 → o_err_energy = (2^24-1) >> 4. Assert i_reset mid-window → all outputs 0 and o_state = 0 the next cycle.

Source files
------------

// File: rtl/ffe_adapt_sequencer.sv
// rtl/ffe_adapt_sequencer.sv - FFE adaptation sequencer: lane rotation, update decimation, CMA/LMS mode FSM, MSE lock detect
// Optional feature macro: MU_ANNEAL_EN (LMS step-size annealing after lock).
module ffe_adapt_sequencer #(
  parameter int PARALLELISM   = 8,
  parameter int NB_OUT        = 18,
  parameter int NBF_OUT       = 15,
  parameter int NB_MU         = 16,
  parameter int NB_ERR_ACC    = 40,
  parameter int DECIM         = 4,
  parameter int ERR_WIN_LOG2  = 10,
  parameter int CMA_MIN_TICKS = 4096,
  parameter int MU_SHIFT_MAX  = 4
) (
  input  logic                              i_clock,
  input  logic                              i_reset,
  input  logic                              i_en,
  input  logic                              i_valid,
  input  logic [PARALLELISM*NB_OUT-1:0]     i_fir_flat,
  input  logic [PARALLELISM*NB_OUT-1:0]     i_slicer_flat,
  input  logic [NB_MU-1:0]                  i_mu_cma,
  input  logic [NB_MU-1:0]                  i_mu_lms,
  input  logic [NB_ERR_ACC-1:0]             i_lock_thr,
  input  logic                              i_freeze,
  input  logic                              i_force_cma,
  output logic [$clog2(PARALLELISM)-1:0]    o_lane_sel,
  output logic [NB_OUT-1:0]                 o_fir_sel,
  output logic [NB_OUT-1:0]                 o_slicer_sel,
  output logic                              o_mode,
  output logic [NB_MU-1:0]                  o_mu,
  output logic                              o_update_en,
  output logic [1:0]                        o_state,
  output logic                              o_locked,
  output logic [NB_ERR_ACC-1:0]             o_err_energy
);

  localparam int DW  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int CW  = $clog2(CMA_MIN_TICKS + 1);
  localparam int SQW = 2 * NB_OUT + 2;
  localparam int SW  = ((SQW > NB_ERR_ACC) ? SQW : NB_ERR_ACC) + 1;
  localparam logic [SW-1:0] ACC_MAX = {{(SW - NB_ERR_ACC){1'b0}}, {NB_ERR_ACC{1'b1}}};

  // e^2 carries 2*NBF_OUT fractional bits, so the sample format must leave room for an integer part.
  if (NBF_OUT >= NB_OUT || DECIM < 1 || ERR_WIN_LOG2 < 1) begin : g_bad_cfg
    $error("ffe_adapt_sequencer: unsupported parameter set");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, CMA_ACQ = 2'd1, LMS_TRACK = 2'd2, FROZEN = 2'd3} state_t;

  state_t                  state, ret_state;
  logic [DW-1:0]           dec_cnt;
  logic [CW-1:0]           cma_cnt;
  logic [ERR_WIN_LOG2-1:0] win_cnt;
  logic [NB_ERR_ACC-1:0]   acc, energy_new;
  logic                    sel_new, win_pend;
  logic                    adv, tick, acc_en, win_end, force_now;
  logic                    cma_sat, energy_lo, energy_hi, lock_evt, unlock_evt;
  logic [NB_OUT-1:0]       fir_lane, slicer_lane;
  logic signed [NB_OUT:0]  err;
  logic signed [SQW-1:0]   err_sq;
  logic [SW-1:0]           err_sq_ext, acc_sum;
  logic [NB_MU-1:0]        mu_lms_next;

  function automatic logic [NB_ERR_ACC-1:0] sat_acc(input logic [SW-1:0] x);
    return (x > ACC_MAX) ? {NB_ERR_ACC{1'b1}} : x[NB_ERR_ACC-1:0];
  endfunction

  assign adv         = i_en && i_valid;
  assign tick        = adv && (dec_cnt == DW'(DECIM - 1));
  assign fir_lane    = i_fir_flat[int'(o_lane_sel)*NB_OUT +: NB_OUT];
  assign slicer_lane = i_slicer_flat[int'(o_lane_sel)*NB_OUT +: NB_OUT];

  assign err        = $signed({o_fir_sel[NB_OUT-1], o_fir_sel}) - $signed({o_slicer_sel[NB_OUT-1], o_slicer_sel});
  assign err_sq     = err * err;
  assign err_sq_ext = SW'($unsigned(err_sq));
  assign acc_sum    = SW'(acc) + err_sq_ext;

  assign acc_en     = i_en && sel_new && (state != IDLE);
  assign win_end    = i_en && win_pend;
  assign force_now  = i_en && i_force_cma && (state != IDLE);
  assign energy_new = acc >> ERR_WIN_LOG2;
  assign energy_lo  = energy_new < i_lock_thr;
  assign energy_hi  = {1'b0, energy_new} >= {i_lock_thr, 1'b0};
  assign cma_sat    = cma_cnt == CW'(CMA_MIN_TICKS);
  assign lock_evt   = (state == CMA_ACQ) && !i_freeze && win_end && cma_sat && energy_lo;
  assign unlock_evt = (state == LMS_TRACK) && !i_freeze && win_end && energy_hi;
  assign o_state    = state;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      dec_cnt      <= '0;
      o_lane_sel   <= '0;
      o_fir_sel    <= '0;
      o_slicer_sel <= '0;
      o_update_en  <= 1'b0;
      sel_new      <= 1'b0;
    end else begin
      o_update_en <= tick && (state == CMA_ACQ || state == LMS_TRACK);
      // A pending accumulation survives an enable drop.
      if (i_en) sel_new <= tick;
      if (adv) dec_cnt <= tick ? '0 : dec_cnt + 1'b1;
      if (tick) begin
        o_fir_sel    <= fir_lane;
        o_slicer_sel <= slicer_lane;
        o_lane_sel   <= o_lane_sel + 1'b1;
      end
    end
  end

  // Window end lands the cycle after the last accumulation of the window.
  always_ff @(posedge i_clock) begin
    if (i_reset || force_now) begin
      acc      <= '0;
      win_cnt  <= '0;
      win_pend <= 1'b0;
      if (i_reset) o_err_energy <= '0;
    end else begin
      if (win_end) begin
        o_err_energy <= energy_new;
        win_pend     <= 1'b0;
        acc          <= acc_en ? sat_acc(err_sq_ext) : '0;
      end else if (acc_en) begin
        acc <= sat_acc(acc_sum);
      end
      if (acc_en) begin
        win_cnt <= win_cnt + 1'b1;
        if (win_cnt == {ERR_WIN_LOG2{1'b1}}) win_pend <= 1'b1;
      end
    end
  end

`ifdef MU_ANNEAL_EN
  localparam int SHW = $clog2(MU_SHIFT_MAX + 1);
  logic [SHW-1:0] mu_shift, shift_inc;
  logic           anneal_evt;

  assign anneal_evt  = (state == LMS_TRACK) && !i_freeze && win_end && energy_lo;
  assign shift_inc   = (mu_shift == SHW'(MU_SHIFT_MAX)) ? mu_shift : mu_shift + 1'b1;
  assign mu_lms_next = $signed(i_mu_lms) >>> (anneal_evt ? shift_inc : mu_shift);

  always_ff @(posedge i_clock) begin
    if (i_reset || force_now || (i_en && lock_evt)) mu_shift <= '0;
    else if (anneal_evt && !force_now) mu_shift <= shift_inc;
  end
`else
  assign mu_lms_next = i_mu_lms;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state     <= IDLE;
      ret_state <= IDLE;
      o_mode    <= 1'b0;
      o_locked  <= 1'b0;
      o_mu      <= '0;
      cma_cnt   <= '0;
    end else if (i_en) begin
      if (force_now) begin
        state    <= CMA_ACQ;
        o_mode   <= 1'b0;
        o_locked <= 1'b0;
        o_mu     <= i_mu_cma;
        cma_cnt  <= '0;
      end else begin
        case (state)
          IDLE: if (i_valid) begin
            state <= CMA_ACQ;
            o_mu  <= i_mu_cma;
          end
          CMA_ACQ: if (i_freeze) begin
            ret_state <= CMA_ACQ;
            state     <= FROZEN;
          end else begin
            o_mu <= i_mu_cma;
            if (tick && !cma_sat) cma_cnt <= cma_cnt + 1'b1;
            if (lock_evt) begin
              state    <= LMS_TRACK;
              o_mode   <= 1'b1;
              o_locked <= 1'b1;
              o_mu     <= i_mu_lms;
            end
          end
          LMS_TRACK: if (i_freeze) begin
            ret_state <= LMS_TRACK;
            state     <= FROZEN;
          end else if (unlock_evt) begin
            state    <= CMA_ACQ;
            o_mode   <= 1'b0;
            o_locked <= 1'b0;
            o_mu     <= i_mu_cma;
            cma_cnt  <= '0;
          end else begin
            o_mu <= mu_lms_next;
          end
          FROZEN: if (!i_freeze) state <= ret_state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ffe_adapt_sequencer.sv
// tb/tb_ffe_adapt_sequencer.sv - directed self-checking bench for ffe_adapt_sequencer
// Annealing expectations follow MU_ANNEAL_EN.
module tb_ffe_adapt_sequencer;

  logic          clk;
  logic          rst, en, valid, freeze, force_cma;
  logic [143:0]  fir_flat, sl_flat;
  logic [15:0]   mu_cma, mu_lms;
  logic [39:0]   thr;
  logic [23:0]   thr2;

  logic [2:0]    lane_sel, lane_sel2;
  logic [17:0]   fir_sel, slicer_sel, fir_sel2, slicer_sel2;
  logic          mode, update_en, locked, mode2, update_en2, locked2;
  logic [15:0]   mu, mu2;
  logic [1:0]    state, state2;
  logic [39:0]   energy;
  logic [23:0]   energy2;

  int checks = 0;
  int errors = 0;

  ffe_adapt_sequencer #(
    .PARALLELISM(8), .NB_OUT(18), .NBF_OUT(15), .NB_MU(16), .NB_ERR_ACC(40),
    .DECIM(4), .ERR_WIN_LOG2(4), .CMA_MIN_TICKS(32), .MU_SHIFT_MAX(4)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_en(en), .i_valid(valid),
    .i_fir_flat(fir_flat), .i_slicer_flat(sl_flat),
    .i_mu_cma(mu_cma), .i_mu_lms(mu_lms), .i_lock_thr(thr),
    .i_freeze(freeze), .i_force_cma(force_cma),
    .o_lane_sel(lane_sel), .o_fir_sel(fir_sel), .o_slicer_sel(slicer_sel),
    .o_mode(mode), .o_mu(mu), .o_update_en(update_en), .o_state(state),
    .o_locked(locked), .o_err_energy(energy)
  );

  ffe_adapt_sequencer #(
    .PARALLELISM(8), .NB_OUT(18), .NBF_OUT(15), .NB_MU(16), .NB_ERR_ACC(24),
    .DECIM(4), .ERR_WIN_LOG2(4), .CMA_MIN_TICKS(32), .MU_SHIFT_MAX(4)
  ) dut_sat (
    .i_clock(clk), .i_reset(rst), .i_en(en), .i_valid(valid),
    .i_fir_flat(fir_flat), .i_slicer_flat(sl_flat),
    .i_mu_cma(mu_cma), .i_mu_lms(mu_lms), .i_lock_thr(thr2),
    .i_freeze(freeze), .i_force_cma(force_cma),
    .o_lane_sel(lane_sel2), .o_fir_sel(fir_sel2), .o_slicer_sel(slicer_sel2),
    .o_mode(mode2), .o_mu(mu2), .o_update_en(update_en2), .o_state(state2),
    .o_locked(locked2), .o_err_energy(energy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MU_ANNEAL_EN
  logic [15:0] mu_exp [5] = '{16'h2000, 16'h1000, 16'h0800, 16'h0400, 16'h0400};
`else
  logic [15:0] mu_exp [5] = '{16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000};
`endif

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_lanes(input int base, input int err);
    for (int k = 0; k < 8; k++) begin
      fir_flat[k*18 +: 18] = 18'(base + k);
      sl_flat[k*18 +: 18]  = 18'(base + k - err);
    end
  endtask

  task automatic set_all(input int fv, input int sv);
    for (int k = 0; k < 8; k++) begin
      fir_flat[k*18 +: 18] = 18'(fv);
      sl_flat[k*18 +: 18]  = 18'(sv);
    end
  endtask

  task automatic do_reset();
    en = 1'b0; valid = 1'b0; freeze = 1'b0; force_cma = 1'b0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    set_lanes(5, 3);
    do_reset();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if ({lane_sel, fir_sel, slicer_sel} !== '0) begin errors++; $display("FAIL reset_sel: got lane %0d fir %0d slc %0d expected 0", lane_sel, fir_sel, slicer_sel); end
    checks++; if ({mode, mu, update_en, locked} !== '0) begin errors++; $display("FAIL reset_ctrl: got mode %0d mu %0h upd %0d lock %0d expected 0", mode, mu, update_en, locked); end
    checks++; if (energy !== 40'd0) begin errors++; $display("FAIL reset_energy: got %0d expected 0", energy); end
  endtask

  task automatic test_rotation();
    int exp_lane, exp_fir;
    logic exp_upd;
    do_reset();
    set_lanes(0, 0);
    en = 1'b1; valid = 1'b1;
    for (int n = 1; n <= 36; n++) begin
      step(1);
      exp_lane = (n / 4) % 8;
      exp_fir  = (n >= 4) ? ((n / 4) - 1) % 8 : 0;
      exp_upd  = (n % 4) == 0;
      checks++; if (update_en !== exp_upd) begin errors++; $display("FAIL rot_upd[%0d]: got %0d expected %0d", n, update_en, exp_upd); end
      checks++; if (lane_sel !== 3'(exp_lane)) begin errors++; $display("FAIL rot_lane[%0d]: got %0d expected %0d", n, lane_sel, exp_lane); end
      checks++; if (fir_sel !== 18'(exp_fir)) begin errors++; $display("FAIL rot_fir[%0d]: got %0d expected %0d", n, fir_sel, exp_fir); end
    end
    checks++; if (state !== 2'd1 || mu !== 16'h1234 || mode !== 1'b0) begin errors++; $display("FAIL rot_cma: got state %0d mu %0h mode %0d expected 1 1234 0", state, mu, mode); end
  endtask

  task automatic test_lock();
    do_reset();
    set_lanes(1000, 32);
    en = 1'b1; valid = 1'b1;
    step(65);
    checks++; if (energy !== 40'd0 || state !== 2'd1) begin errors++; $display("FAIL lock_pre_win: got energy %0d state %0d expected 0 1", energy, state); end
    step(1);
    checks++; if (energy !== 40'd1024) begin errors++; $display("FAIL lock_win1_energy: got %0d expected 1024", energy); end
    checks++; if (state !== 2'd1 || locked !== 1'b0) begin errors++; $display("FAIL lock_win1_state: got state %0d lock %0d expected 1 0", state, locked); end
    step(63);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL lock_early: got state %0d expected 1", state); end
    step(1);
    checks++; if (state !== 2'd2 || locked !== 1'b1 || mode !== 1'b1) begin errors++; $display("FAIL lock_enter: got state %0d lock %0d mode %0d expected 2 1 1", state, locked, mode); end
    checks++; if (mu !== 16'h4000) begin errors++; $display("FAIL lock_mu0: got %0h expected 4000", mu); end
    step(2);
    checks++; if (update_en !== 1'b1) begin errors++; $display("FAIL lock_upd: got %0d expected 1", update_en); end
    step(62);
    for (int m = 0; m < 5; m++) begin
      if (m > 0) step(64);
      checks++; if (mu !== mu_exp[m]) begin errors++; $display("FAIL anneal_mu[%0d]: got %0h expected %0h", m, mu, mu_exp[m]); end
    end
  endtask

  task automatic test_unlock();
    set_lanes(1000, 2048);
    step(63);
    checks++; if (state !== 2'd2 || locked !== 1'b1) begin errors++; $display("FAIL unlock_early: got state %0d lock %0d expected 2 1", state, locked); end
    step(1);
    checks++; if (state !== 2'd1 || locked !== 1'b0 || mode !== 1'b0) begin errors++; $display("FAIL unlock_state: got state %0d lock %0d mode %0d expected 1 0 0", state, locked, mode); end
    checks++; if (mu !== 16'h1234) begin errors++; $display("FAIL unlock_mu: got %0h expected 1234", mu); end
    checks++; if (energy !== 40'd4194304) begin errors++; $display("FAIL unlock_energy: got %0d expected 4194304", energy); end
  endtask

  task automatic test_freeze_force();
    int pulses, bad_state;
    do_reset();
    set_lanes(1000, 32);
    en = 1'b1; valid = 1'b1;
    step(130);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL frz_lock: got state %0d expected 2", state); end
    step(64);
    freeze = 1'b1;
    step(1);
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL frz_enter: got state %0d expected 3", state); end
    pulses = 0; bad_state = 0;
    for (int n = 0; n < 65; n++) begin
      step(1);
      if (update_en) pulses++;
      if (state != 2'd3) bad_state++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL frz_no_update: got %0d pulses expected 0", pulses); end
    checks++; if (bad_state != 0) begin errors++; $display("FAIL frz_hold_state: got %0d non-frozen cycles expected 0", bad_state); end
    checks++; if (mu !== mu_exp[0] || locked !== 1'b1 || mode !== 1'b1) begin errors++; $display("FAIL frz_hold_ctrl: got mu %0h lock %0d mode %0d expected %0h 1 1", mu, locked, mode, mu_exp[0]); end
    freeze = 1'b0;
    step(1);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL frz_release: got state %0d expected 2", state); end
    step(1);
    checks++; if (mu !== mu_exp[0]) begin errors++; $display("FAIL frz_shift_kept: got mu %0h expected %0h", mu, mu_exp[0]); end
    force_cma = 1'b1;
    step(1);
    force_cma = 1'b0;
    checks++; if (state !== 2'd1 || locked !== 1'b0 || mode !== 1'b0) begin errors++; $display("FAIL force_state: got state %0d lock %0d mode %0d expected 1 0 0", state, locked, mode); end
    checks++; if (mu !== 16'h1234) begin errors++; $display("FAIL force_mu: got %0h expected 1234", mu); end
  endtask

  task automatic test_enable();
    do_reset();
    set_lanes(10, 0);
    en = 1'b1; valid = 1'b1;
    step(6);
    checks++; if (lane_sel !== 3'd1 || fir_sel !== 18'd10 || state !== 2'd1) begin errors++; $display("FAIL en_pre: got lane %0d fir %0d state %0d expected 1 10 1", lane_sel, fir_sel, state); end
    en = 1'b0;
    for (int n = 0; n < 10; n++) begin
      step(1);
      checks++; if (update_en !== 1'b0 || lane_sel !== 3'd1 || fir_sel !== 18'd10 || state !== 2'd1) begin
        errors++; $display("FAIL en_hold[%0d]: got upd %0d lane %0d fir %0d state %0d expected 0 1 10 1", n, update_en, lane_sel, fir_sel, state);
      end
    end
    en = 1'b1;
    step(1);
    checks++; if (update_en !== 1'b0 || lane_sel !== 3'd1) begin errors++; $display("FAIL en_resume1: got upd %0d lane %0d expected 0 1", update_en, lane_sel); end
    step(1);
    checks++; if (update_en !== 1'b1 || lane_sel !== 3'd2 || fir_sel !== 18'd11) begin errors++; $display("FAIL en_resume2: got upd %0d lane %0d fir %0d expected 1 2 11", update_en, lane_sel, fir_sel); end
  endtask

  task automatic test_saturation_reset();
    do_reset();
    set_all(65208, -65208);
    en = 1'b1; valid = 1'b1;
    step(65);
    checks++; if (energy2 !== 24'd0) begin errors++; $display("FAIL sat_pre: got %0d expected 0", energy2); end
    step(1);
    checks++; if (energy2 !== 24'h0FFFFF) begin errors++; $display("FAIL sat_energy24: got %0h expected fffff", energy2); end
    checks++; if (energy !== 40'd17008333056) begin errors++; $display("FAIL sat_energy40: got %0d expected 17008333056", energy); end
    step(10);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++; if (state !== 2'd0 || energy !== 40'd0 || locked !== 1'b0) begin errors++; $display("FAIL midrst_state: got state %0d energy %0d lock %0d expected 0 0 0", state, energy, locked); end
    checks++; if ({lane_sel, fir_sel, slicer_sel, mode, mu, update_en} !== '0) begin errors++; $display("FAIL midrst_outs: got lane %0d fir %0d slc %0d mode %0d mu %0h upd %0d expected 0", lane_sel, fir_sel, slicer_sel, mode, mu, update_en); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; valid = 1'b0; freeze = 1'b0; force_cma = 1'b0;
    fir_flat = '0; sl_flat = '0;
    mu_cma = 16'h1234; mu_lms = 16'h4000;
    thr = 40'd1048576; thr2 = 24'd1048576;
    test_reset();
    test_rotation();
    test_lock();
    test_unlock();
    test_freeze_force();
    test_enable();
    test_saturation_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
